// File: rtl/atto_cfg_pkg.sv
// Shared constants for the atto-FPGA configuration byte protocol.
// Imported by both the streamer and the receiving unit.
package atto_cfg_pkg;

  localparam logic [7:0] CMD_OUT       = 8'h7F;
  localparam logic [7:0] IDLE_BYTE     = 8'h00;
  localparam int unsigned CMD_BLOCK_BIT = 7;

  localparam logic [1:0] CFG_X  = 2'd0;
  localparam logic [1:0] CFG_Y  = 2'd1;
  localparam logic [1:0] CFG_AB = 2'd2;
  localparam logic [1:0] CFG_CX = 2'd3;

  localparam int unsigned NUM_LAYERS = 4;
  localparam int unsigned NUM_BITS   = 8;

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StCmd  = 2'd1;
  localparam state_t StData = 2'd2;
  localparam state_t StGap  = 2'd3;

  function automatic logic [7:0] block_cmd(input logic [1:0] layer, input logic [2:0] bits,
                                           input logic [1:0] cfg);
    return {1'b1, layer, bits, cfg};
  endfunction

endpackage

// File: rtl/cfg_streamer.sv
// Serialises configuration records into the unit's command/data byte stream and can run a
// self-timed sweep that zeroes every block entry and the output mask.
module cfg_streamer
  import atto_cfg_pkg::*;
#(
  parameter int unsigned GAP = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rec_valid_i,
  output logic       rec_ready_o,
  input  logic       rec_kind_i,
  input  logic [6:0] rec_addr_i,
  input  logic [7:0] rec_data_i,
  input  logic       clear_req_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] cfg_out_o
);

  localparam logic [3:0] GapLast = 4'(GAP) - 4'd1;

  state_t     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] dat_q, dat_d;
  logic [7:0] out_q, out_d;
  logic [6:0] addr_q, addr_d;
  logic [3:0] gap_q, gap_d;
  logic       mask_q, mask_d;
  logic       sweep_q, sweep_d;
  logic       done_q, done_d;
  logic       accept, do_load, do_adv, do_fin;

  // A clear request in IDLE pre-empts a record offered in the same cycle.
  assign rec_ready_o = ((state_q == StIdle) && !clear_req_i) ||
                       ((state_q == StData) && (GAP == 0) && !sweep_q);
  assign accept      = rec_valid_i && rec_ready_o;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign cfg_out_o   = out_q;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    dat_d   = dat_q;
    addr_d  = addr_q;
    gap_d   = gap_q;
    mask_d  = mask_q;
    sweep_d = sweep_q;
    done_d  = 1'b0;
    do_load = 1'b0;
    do_adv  = 1'b0;
    do_fin  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clear_req_i) begin
          sweep_d = 1'b1;
          mask_d  = 1'b0;
          addr_d  = '0;
          cmd_d   = block_cmd(2'd0, 3'd0, 2'd0);
          dat_d   = IDLE_BYTE;
          state_d = StCmd;
        end else if (accept) begin
          do_load = 1'b1;
        end
      end
      StCmd: state_d = StData;
      StData: begin
        if (GAP != 0) begin
          state_d = StGap;
          gap_d   = GapLast;
        end else if (sweep_q) begin
          do_fin = mask_q;
          do_adv = !mask_q;
        end else if (accept) begin
          do_load = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else if (sweep_q) begin
          do_fin = mask_q;
          do_adv = !mask_q;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_load) begin
      cmd_d   = rec_kind_i ? CMD_OUT : block_cmd(rec_addr_i[6:5], rec_addr_i[4:2], rec_addr_i[1:0]);
      dat_d   = rec_data_i;
      state_d = StCmd;
    end
    // Sweep walks block addresses upward, then finishes with the output-mask record.
    if (do_adv) begin
      state_d = StCmd;
      if (addr_q == 7'h7F) begin
        mask_d = 1'b1;
        cmd_d  = CMD_OUT;
      end else begin
        addr_d = addr_q + 7'd1;
        cmd_d  = {1'b1, addr_q + 7'd1};
      end
    end
    if (do_fin) begin
      state_d = StIdle;
      sweep_d = 1'b0;
      mask_d  = 1'b0;
      done_d  = 1'b1;
    end

    unique case (state_d)
      StCmd:   out_d = cmd_d;
      StData:  out_d = dat_q;
      default: out_d = IDLE_BYTE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cmd_q   <= IDLE_BYTE;
      dat_q   <= IDLE_BYTE;
      out_q   <= IDLE_BYTE;
      addr_q  <= '0;
      gap_q   <= '0;
      mask_q  <= 1'b0;
      sweep_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      dat_q   <= dat_d;
      out_q   <= out_d;
      addr_q  <= addr_d;
      gap_q   <= gap_d;
      mask_q  <= mask_d;
      sweep_q <= sweep_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_cfg_streamer.sv
// Bench for cfg_streamer: directed scenarios plus random traffic against a byte-queue model,
// on one instance with no gap and one with a three-byte gap.
module tb_cfg_streamer;

  logic       clk = 1'b0;
  logic       rst, valid, kind, clr;
  logic [6:0] addr;
  logic [7:0] data;
  logic       rdy0, busy0, done0, rdy3, busy3, done3;
  logic [7:0] out0, out3;
  logic       sel;
  logic       obs_ready, obs_busy, obs_done;
  logic [7:0] obs_out;

  int errors = 0;
  int checks = 0;
  int g = 0;

  typedef struct packed {
    logic [7:0] b;
    logic       own;
    logic       swp;
    logic       last;
  } ent_t;

  ent_t q[$];
  ent_t cur, prev;

  always #5 clk = ~clk;

  cfg_streamer #(.GAP(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .rec_valid_i(valid), .rec_ready_o(rdy0), .rec_kind_i(kind),
    .rec_addr_i(addr), .rec_data_i(data), .clear_req_i(clr), .busy_o(busy0), .done_o(done0),
    .cfg_out_o(out0)
  );

  cfg_streamer #(.GAP(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .rec_valid_i(valid), .rec_ready_o(rdy3), .rec_kind_i(kind),
    .rec_addr_i(addr), .rec_data_i(data), .clear_req_i(clr), .busy_o(busy3), .done_o(done3),
    .cfg_out_o(out3)
  );

  assign obs_ready = sel ? rdy3 : rdy0;
  assign obs_busy  = sel ? busy3 : busy0;
  assign obs_done  = sel ? done3 : done0;
  assign obs_out   = sel ? out3 : out0;

  // Model: every accepted record queues its bytes; one byte leaves per cycle, idle when empty.
  task automatic model_flush();
    q.delete();
    cur  = '0;
    prev = '0;
  endtask

  task automatic model_pop();
    prev = cur;
    if (q.size() != 0) cur = q.pop_front();
    else cur = '0;
  endtask

  function automatic logic model_ready(input logic c);
    if (c && !cur.own) return 1'b0;
    if (q.size() != 0) return 1'b0;
    return !(cur.own && (g > 0 || cur.swp));
  endfunction

  task automatic model_push(input logic [7:0] c, input logic [7:0] d, input logic s,
                            input logic fin);
    q.push_back('{b: c, own: 1'b1, swp: s, last: 1'b0});
    q.push_back('{b: d, own: 1'b1, swp: s, last: fin && (g == 0)});
    for (int j = 0; j < g; j++) q.push_back('{b: 8'h00, own: 1'b1, swp: s, last: fin && (j == g - 1)});
  endtask

  task automatic model_sweep();
    for (int i = 0; i < 129; i++) begin
      logic [7:0] c;
      c = (i < 128) ? (8'h80 + 8'(i)) : 8'h7F;
      model_push(c, 8'h00, 1'b1, i == 128);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; kind = 1'b0; addr = '0; data = '0; clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_flush();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (out0 !== 8'h00 || out3 !== 8'h00) begin errors++; $display("FAIL reset_out: got %h/%h want 00", out0, out3); end
    checks++; if (busy0 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b/%b want 0", busy0, busy3); end
    checks++; if (done0 !== 1'b0 || done3 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b/%b want 0", done0, done3); end
    checks++; if (rdy0 !== 1'b1 || rdy3 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b/%b want 1", rdy0, rdy3); end
  endtask

  task automatic test_record(input string nm, input logic k, input logic [6:0] a,
                             input logic [7:0] d, input logic [7:0] want_cmd);
    logic [7:0] want [3];
    sel = 1'b0;
    do_reset();
    want[0] = want_cmd; want[1] = d; want[2] = 8'h00;
    @(negedge clk);
    valid = 1'b1; kind = k; addr = a; data = d;
    #1;
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b want 1", nm, obs_ready); end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      valid = 1'b0;
      checks++; if (obs_out !== want[n]) begin errors++; $display("FAIL %s_byte%0d: got %h want %h", nm, n, obs_out, want[n]); end
      checks++; if (obs_busy !== (n < 2)) begin errors++; $display("FAIL %s_busy%0d: got %b want %b", nm, n, obs_busy, n < 2); end
    end
  endtask

  task automatic test_gap();
    logic [7:0] want [8];
    sel = 1'b1; g = 3;
    do_reset();
    want = '{8'h91, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h81};
    @(negedge clk);
    valid = 1'b1; kind = 1'b0; addr = 7'h11; data = 8'h3C;
    #1;
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL gap_ready0: got %b want 1", obs_ready); end
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) begin kind = 1'b1; data = 8'h81; end
      if (n == 7) valid = 1'b0;
      #1;
      checks++; if (obs_out !== want[n-1]) begin errors++; $display("FAIL gap_byte%0d: got %h want %h", n, obs_out, want[n-1]); end
      checks++; if (obs_busy !== (n != 6)) begin errors++; $display("FAIL gap_busy%0d: got %b want %b", n, obs_busy, n != 6); end
      if (n <= 6) begin
        checks++; if (obs_ready !== (n == 6)) begin errors++; $display("FAIL gap_ready%0d: got %b want %b", n, obs_ready, n == 6); end
      end
    end
  endtask

  task automatic test_clear();
    logic [7:0] w;
    sel = 1'b0; g = 0;
    do_reset();
    @(negedge clk);
    clr = 1'b1; valid = 1'b1; kind = 1'b0; addr = 7'h05; data = 8'hEE;
    #1;
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL clear_wins: got ready %b want 0", obs_ready); end
    for (int n = 1; n <= 260; n++) begin
      @(negedge clk);
      clr = (n == 5);
      #1;
      if (n <= 258 && (n % 2) == 1) w = ((n - 1) / 2 < 128) ? 8'(8'h80 + (n - 1) / 2) : 8'h7F;
      else w = 8'h00;
      checks++; if (obs_out !== w) begin errors++; $display("FAIL clear_byte%0d: got %h want %h", n, obs_out, w); end
      checks++; if (obs_busy !== (n <= 258)) begin errors++; $display("FAIL clear_busy%0d: got %b want %b", n, obs_busy, n <= 258); end
      checks++; if (obs_done !== (n == 259)) begin errors++; $display("FAIL clear_done%0d: got %b want %b", n, obs_done, n == 259); end
      if (n <= 259) begin
        checks++; if (obs_ready !== (n == 259)) begin errors++; $display("FAIL clear_ready%0d: got %b want %b", n, obs_ready, n == 259); end
      end
      if (n == 259) valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0; g = 0;
    do_reset();
    @(negedge clk);
    valid = 1'b1; kind = 1'b0; addr = 7'h40; data = 8'h55;
    @(negedge clk);
    valid = 1'b0;
    checks++; if (obs_out !== 8'hC0) begin errors++; $display("FAIL rstmid_cmd: got %h want c0", obs_out); end
    rst = 1'b1;
    for (int n = 2; n <= 6; n++) begin
      @(negedge clk);
      rst = 1'b0;
      checks++; if (obs_out !== 8'h00) begin errors++; $display("FAIL rstmid_out%0d: got %h want 00", n, obs_out); end
      checks++; if (obs_busy !== 1'b0 || obs_done !== 1'b0) begin
        errors++; $display("FAIL rstmid_flags%0d: got busy %b done %b want 0 0", n, obs_busy, obs_done);
      end
    end
  endtask

  task automatic test_stream(input logic s, input int ncyc, input int clear_pct);
    logic rexp;
    sel = s; g = s ? 3 : 0;
    do_reset();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      model_pop();
      checks++; if (obs_out !== cur.b) begin errors++; $display("FAIL stream%0d_out@%0d: got %h want %h", g, i, obs_out, cur.b); end
      checks++; if (obs_busy !== cur.own) begin errors++; $display("FAIL stream%0d_busy@%0d: got %b want %b", g, i, obs_busy, cur.own); end
      checks++; if (obs_done !== prev.last) begin errors++; $display("FAIL stream%0d_done@%0d: got %b want %b", g, i, obs_done, prev.last); end
      valid = ($urandom % 4) != 0;
      kind  = ($urandom % 4) == 0;
      addr  = 7'($urandom);
      data  = 8'($urandom);
      clr   = int'($urandom % 100) < clear_pct;
      #1;
      rexp = model_ready(clr);
      checks++; if (obs_ready !== rexp) begin errors++; $display("FAIL stream%0d_ready@%0d: got %b want %b", g, i, obs_ready, rexp); end
      if (valid && rexp) model_push(kind ? 8'h7F : {1'b1, addr}, data, 1'b0, 1'b0);
      else if (clr && !cur.own) model_sweep();
    end
    valid = 1'b0; clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; kind = 1'b0; addr = '0; data = '0; clr = 1'b0; sel = 1'b0;
    model_flush();
    test_reset();
    test_record("block", 1'b0, 7'h25, 8'hA5, 8'hA5);
    test_record("mask", 1'b1, 7'h25, 8'h7F, 8'h7F);
    test_record("bigdata", 1'b0, 7'h03, 8'hFE, 8'h83);
    test_gap();
    test_clear();
    test_reset_mid();
    test_stream(1'b0, 600, 0);
    test_stream(1'b0, 900, 1);
    test_stream(1'b1, 1600, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
